// File: rtl/lr35902_oam_port_if.sv
// OAM bus bundle: CPU window (FE00-FE9F), OAM DMA write port and PPU read port.
// The slave modport is the OAM responder; the master modport is the agent side.
// No flow control: every strobe is serviced in the cycle it is presented.
interface lr35902_oam_port_if;
  // CPU bus decoder side
  logic [7:0] cpu_adr;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;
  logic       cpu_read;
  logic       cpu_write;
  logic       cpu_blocked;
  // OAM DMA engine side
  logic       dma_active;
  logic [7:0] dma_adr;
  logic [7:0] dma_din;
  logic       dma_write;
  // PPU side
  logic       ppu_lock;
  logic [7:0] ppu_adr;
  logic       ppu_read;
  logic [7:0] ppu_dout;

  modport slave (
    input  cpu_adr, cpu_din, cpu_read, cpu_write,
    input  dma_active, dma_adr, dma_din, dma_write,
    input  ppu_lock, ppu_adr, ppu_read,
    output cpu_dout, ppu_dout, cpu_blocked
  );

  modport master (
    output cpu_adr, cpu_din, cpu_read, cpu_write,
    output dma_active, dma_adr, dma_din, dma_write,
    output ppu_lock, ppu_adr, ppu_read,
    input  cpu_dout, ppu_dout, cpu_blocked
  );
endinterface

// File: rtl/lr35902_oam_port.sv
// OAM responder: owns the SIZE-byte object attribute memory, arbitrates DMA / PPU / CPU.
// Latency: writes land at the clock edge; cpu_dout / ppu_dout are registered, 1 cycle after the strobe.
// No backpressure: a blocked CPU access is ignored (reads return OPEN_BUS), cpu_blocked flags it.
//
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : lr35902_oam_port_if.slave
//                cpu_adr/cpu_din/cpu_read/cpu_write -> cpu_dout, cpu_blocked
//                dma_active/dma_adr/dma_din/dma_write (write-only, highest priority)
//                ppu_lock/ppu_adr/ppu_read -> ppu_dout
module lr35902_oam_port #(
  parameter int         SIZE     = 160,
  parameter logic [7:0] OPEN_BUS = 8'hff
) (
  input  logic              clk,
  input  logic              reset,
  lr35902_oam_port_if.slave bus
);

  localparam logic [8:0] SIZE_W = 9'(SIZE);

  typedef enum logic [1:0] {
    OWN_FREE,
    OWN_DMA,
    OWN_PPU,
    OWN_GUARD
  } owner_e;

  owner_e     owner_q;

  // Storage is deliberately not reset.
  logic [7:0] mem [SIZE];

  // CPU write tracking: the strobe is a level, the commit happens on its
  // falling edge with the address/data/blocked state of the last high cycle.
  logic       wr_q;
  logic [7:0] wr_adr_q;
  logic [7:0] wr_din_q;
  logic       wr_blk_q;

  logic [7:0] cpu_dout_q, cpu_dout_d;
  logic [7:0] ppu_dout_q, ppu_dout_d;

  logic       cpu_blocked;
  logic       dma_map, ppu_map, cpu_map, wr_map;
  logic       dma_hit;
  logic       cpu_commit;
  logic [7:0] ppu_fwd, cpu_fwd;

  // Address decode: anything at or above SIZE is unmapped.
  always_comb begin
    dma_map = ({1'b0, bus.dma_adr}  < SIZE_W);
    ppu_map = ({1'b0, bus.ppu_adr}  < SIZE_W);
    cpu_map = ({1'b0, bus.cpu_adr}  < SIZE_W);
    wr_map  = ({1'b0, wr_adr_q}     < SIZE_W);
  end

  // Blocking reacts to the request inputs in the same cycle; the owner term
  // keeps the CPU out for the hand-over cycles after a request drops.
  assign cpu_blocked = (owner_q != OWN_FREE) || bus.dma_active || bus.ppu_lock;

  // DMA writes are honoured in every owner state, even with dma_active low.
  assign dma_hit = bus.dma_write && dma_map;

  // A DMA write to the same byte in the commit cycle wins over the CPU.
  assign cpu_commit = wr_q && !bus.cpu_write && !wr_blk_q && wr_map &&
                      !(dma_hit && (bus.dma_adr == wr_adr_q));

  // Write-first read paths: a read of the byte being written this cycle
  // returns the new data. The two write ports never target the same byte.
  always_comb begin
    ppu_fwd = mem[bus.ppu_adr];
    if (dma_hit && (bus.dma_adr == bus.ppu_adr)) begin
      ppu_fwd = bus.dma_din;
    end else if (cpu_commit && (wr_adr_q == bus.ppu_adr)) begin
      ppu_fwd = wr_din_q;
    end
  end

  always_comb begin
    cpu_fwd = mem[bus.cpu_adr];
    if (dma_hit && (bus.dma_adr == bus.cpu_adr)) begin
      cpu_fwd = bus.dma_din;
    end else if (cpu_commit && (wr_adr_q == bus.cpu_adr)) begin
      cpu_fwd = wr_din_q;
    end
  end

  always_comb begin
    cpu_dout_d = cpu_dout_q;
    if (bus.cpu_read) begin
      cpu_dout_d = (cpu_blocked || !cpu_map) ? OPEN_BUS : cpu_fwd;
    end
  end

  always_comb begin
    ppu_dout_d = ppu_dout_q;
    if (bus.ppu_read) begin
      ppu_dout_d = ppu_map ? ppu_fwd : 8'h00;
    end
  end

  // Owner state machine. DMA always wins; leaving DMA straight into a pending
  // PPU lock skips the guard cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= OWN_FREE;
    end else begin
      case (owner_q)
        OWN_FREE: begin
          if (bus.dma_active)    owner_q <= OWN_DMA;
          else if (bus.ppu_lock) owner_q <= OWN_PPU;
        end
        OWN_DMA: begin
          if (!bus.dma_active) owner_q <= bus.ppu_lock ? OWN_PPU : OWN_GUARD;
        end
        OWN_PPU: begin
          if (bus.dma_active)     owner_q <= OWN_DMA;
          else if (!bus.ppu_lock) owner_q <= OWN_GUARD;
        end
        OWN_GUARD: begin
          if (bus.dma_active)    owner_q <= OWN_DMA;
          else if (bus.ppu_lock) owner_q <= OWN_PPU;
          else                   owner_q <= OWN_FREE;
        end
        default: owner_q <= OWN_FREE;
      endcase
    end
  end

  // CPU write capture and registered read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q       <= 1'b0;
      wr_adr_q   <= 8'h00;
      wr_din_q   <= 8'h00;
      wr_blk_q   <= 1'b0;
      cpu_dout_q <= 8'hff;
      ppu_dout_q <= 8'hff;
    end else begin
      wr_q <= bus.cpu_write;
      if (bus.cpu_write) begin
        wr_adr_q <= bus.cpu_adr;
        wr_din_q <= bus.cpu_din;
        wr_blk_q <= cpu_blocked;
      end
      cpu_dout_q <= cpu_dout_d;
      ppu_dout_q <= ppu_dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cpu_commit) mem[wr_adr_q]    <= wr_din_q;
    if (dma_hit)    mem[bus.dma_adr] <= bus.dma_din;
  end

  assign bus.cpu_dout    = cpu_dout_q;
  assign bus.ppu_dout    = ppu_dout_q;
  assign bus.cpu_blocked = cpu_blocked;

endmodule

// File: tb/tb_lr35902_oam_port.sv
// Bench for lr35902_oam_port: directed scenarios then random traffic.
// A per-cycle reference model queues expected outputs; a negedge monitor compares.
// No backpressure on the DUT; every queued expectation has a fixed due cycle.
module tb_lr35902_oam_port;
  localparam int SIZE = 160;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  lr35902_oam_port_if bus_if ();

  lr35902_oam_port #(.SIZE(SIZE), .OPEN_BUS(8'hff)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  typedef struct packed {
    logic [7:0] cpu_adr;
    logic [7:0] cpu_din;
    logic       cpu_read;
    logic       cpu_write;
    logic       dma_active;
    logic [7:0] dma_adr;
    logic [7:0] dma_din;
    logic       dma_write;
    logic       ppu_lock;
    logic [7:0] ppu_adr;
    logic       ppu_read;
  } stim_t;

  typedef struct {
    int         due;
    int         kind;   // 0 cpu_dout, 1 ppu_dout, 2 cpu_blocked
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  bit in_reset = 1'b1;

  // Reference model state.
  logic [7:0] mm [256];
  bit         mk [256];
  bit         hist1, hist2;          // any request in the previous / second previous cycle
  bit         pend_v, pend_blk;
  logic [7:0] pend_adr, pend_din;
  logic [7:0] cpu_hold, ppu_hold;
  bit         cpu_known, ppu_known;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d: got %02h expected %02h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input stim_t s);
    bus_if.cpu_adr    = s.cpu_adr;
    bus_if.cpu_din    = s.cpu_din;
    bus_if.cpu_read   = s.cpu_read;
    bus_if.cpu_write  = s.cpu_write;
    bus_if.dma_active = s.dma_active;
    bus_if.dma_adr    = s.dma_adr;
    bus_if.dma_din    = s.dma_din;
    bus_if.dma_write  = s.dma_write;
    bus_if.ppu_lock   = s.ppu_lock;
    bus_if.ppu_adr    = s.ppu_adr;
    bus_if.ppu_read   = s.ppu_read;
  endtask

  task automatic reset_model();
    sb.delete();
    hist1 = 0; hist2 = 0;
    pend_v = 0; pend_blk = 0;
    cpu_hold = 8'hff; ppu_hold = 8'hff;
    cpu_known = 1; ppu_known = 1;
  endtask

  // Rules: the CPU is shut out while any request is up and for two cycles
  // after the last one; writes of this cycle are visible to reads of this cycle.
  task automatic model(input stim_t s);
    int  c = cyc;
    bit  blk, dma_w, cpu_c;
    exp_t e;
    blk   = s.dma_active || s.ppu_lock || hist1 || hist2;
    dma_w = s.dma_write && (int'(s.dma_adr) < SIZE);
    cpu_c = pend_v && !s.cpu_write && !pend_blk && (int'(pend_adr) < SIZE) &&
            !(dma_w && (s.dma_adr == pend_adr));
    e.due = c; e.kind = 2; e.val = {7'b0, blk}; sb.push_back(e);
    if (cpu_c) begin mm[pend_adr] = pend_din; mk[pend_adr] = 1; end
    if (dma_w) begin mm[s.dma_adr] = s.dma_din; mk[s.dma_adr] = 1; end
    if (s.ppu_read) begin
      if (int'(s.ppu_adr) >= SIZE) begin ppu_hold = 8'h00; ppu_known = 1; end
      else begin ppu_hold = mm[s.ppu_adr]; ppu_known = mk[s.ppu_adr]; end
    end
    if (s.cpu_read) begin
      if (blk || int'(s.cpu_adr) >= SIZE) begin cpu_hold = 8'hff; cpu_known = 1; end
      else begin cpu_hold = mm[s.cpu_adr]; cpu_known = mk[s.cpu_adr]; end
    end
    if (cpu_known) begin e.due = c + 1; e.kind = 0; e.val = cpu_hold; sb.push_back(e); end
    if (ppu_known) begin e.due = c + 1; e.kind = 1; e.val = ppu_hold; sb.push_back(e); end
    if (s.cpu_write) begin
      pend_v = 1; pend_adr = s.cpu_adr; pend_din = s.cpu_din; pend_blk = blk;
    end else begin
      pend_v = 0;
    end
    hist2 = hist1;
    hist1 = s.dma_active || s.ppu_lock;
  endtask

  task automatic step(input stim_t s);
    @(posedge clk);
    #1;
    drive(s);
    model(s);
  endtask

  // Monitor: pops every expectation due this cycle.
  always @(negedge clk) begin
    if (!in_reset) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        case (e.kind)
          0:       chk("cpu_dout", bus_if.cpu_dout, e.val);
          1:       chk("ppu_dout", bus_if.ppu_dout, e.val);
          default: chk("cpu_blocked", {7'b0, bus_if.cpu_blocked}, e.val);
        endcase
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    stim_t s;
    bit da, pl;
    s = '0;
    for (int i = 0; i < 256; i++) begin mm[i] = 8'h00; mk[i] = 0; end
    drive(s);

    // Power-on reset.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_dout", bus_if.cpu_dout, 8'hff);
    chk("rst_ppu_dout", bus_if.ppu_dout, 8'hff);
    chk("rst_blocked", {7'b0, bus_if.cpu_blocked}, 8'h00);
    #1;
    reset = 1'b0;
    reset_model();
    in_reset = 0;

    // CPU write 5a to 0x10 then read it back.
    s = '0; s.cpu_adr = 8'h10; s.cpu_din = 8'h5a; s.cpu_write = 1;
    step(s); step(s);
    s.cpu_write = 0; step(s);
    s.cpu_read = 1; step(s);
    s.cpu_read = 0; step(s); step(s);

    // DMA fill with ~adr, CPU activity concurrent with it.
    s = '0; s.dma_active = 1; step(s);
    for (int a = 0; a < SIZE; a++) begin
      s.dma_write = 1; s.dma_adr = 8'(a); s.dma_din = ~8'(a);
      s.cpu_read  = (a == 5);
      s.cpu_adr   = (a == 5) ? 8'h10 : 8'h20;
      s.cpu_din   = 8'h77;
      s.cpu_write = (a >= 40 && a < 42);
      step(s); step(s);
    end
    s.dma_write = 0; s.cpu_write = 0; s.cpu_read = 0;
    s.ppu_read = 1; s.ppu_adr = 8'h00; step(s);
    s.ppu_adr = 8'h9f; step(s);
    s.ppu_read = 0; step(s);
    s.dma_active = 0; step(s); step(s); step(s);
    s.cpu_read = 1; s.cpu_adr = 8'h20; step(s);
    s.cpu_read = 0; step(s); step(s);

    // PPU lock and the hand-over cycles after it drops.
    s = '0; s.ppu_lock = 1; step(s);
    s.cpu_read = 1; s.cpu_adr = 8'h04; step(s);
    s.ppu_lock = 0; step(s); step(s); step(s);
    s.cpu_read = 0; step(s); step(s);

    // Unmapped addresses.
    s = '0; s.cpu_read = 1; s.cpu_adr = 8'ha0; s.ppu_read = 1; s.ppu_adr = 8'ha5; step(s);
    s = '0; s.cpu_write = 1; s.cpu_adr = 8'ha0; s.cpu_din = 8'h33; step(s);
    s.cpu_write = 0; step(s);
    s = '0; s.cpu_read = 1; s.cpu_adr = 8'h00; s.ppu_read = 1; s.ppu_adr = 8'h00; step(s);
    s = '0; step(s); step(s);

    // DMA and CPU commit to the same byte in the same cycle.
    s = '0; s.cpu_write = 1; s.cpu_adr = 8'h30; s.cpu_din = 8'h22; step(s);
    s.cpu_write = 0; s.dma_write = 1; s.dma_adr = 8'h30; s.dma_din = 8'h11;
    s.ppu_read = 1; s.ppu_adr = 8'h30; step(s);
    s = '0; s.cpu_read = 1; s.cpu_adr = 8'h30; step(s);
    s = '0; step(s); step(s); step(s);

    // PPU lock rising during DMA, then DMA ends with the lock still up.
    s = '0; s.dma_active = 1; step(s); step(s);
    s.ppu_lock = 1; step(s); step(s);
    s.dma_active = 0; step(s); step(s); step(s);
    s.ppu_lock = 0; step(s); step(s); step(s); step(s);

    // Reset mid-DMA with cpu_write high.
    s = '0; s.dma_active = 1; s.dma_write = 1; s.dma_adr = 8'h40; s.dma_din = 8'h55;
    s.cpu_write = 1; s.cpu_adr = 8'h50; s.cpu_din = 8'haa;
    s.ppu_read = 1; s.ppu_adr = 8'h01;
    step(s); step(s);
    #2;
    reset = 1'b1; in_reset = 1;
    s.dma_write = 0; s.ppu_read = 0; drive(s);
    #1;
    chk("mid_rst_cpu_dout", bus_if.cpu_dout, 8'hff);
    chk("mid_rst_ppu_dout", bus_if.ppu_dout, 8'hff);
    chk("mid_rst_blocked", {7'b0, bus_if.cpu_blocked}, 8'h01);
    repeat (2) @(posedge clk);
    #1;
    s.dma_active = 0; drive(s);
    #1;
    chk("rst_owner_free", {7'b0, bus_if.cpu_blocked}, 8'h00);
    s.cpu_write = 0; drive(s);
    reset = 1'b0;
    reset_model();
    in_reset = 0;
    s = '0; s.cpu_read = 1; s.cpu_adr = 8'h50; step(s);
    s = '0; step(s); step(s);

    // Reset while an unblocked CPU write is pending.
    s = '0; s.cpu_read = 1; s.cpu_adr = 8'h10; step(s);
    s = '0; s.cpu_write = 1; s.cpu_adr = 8'h60; s.cpu_din = 8'haa; step(s); step(s);
    #2;
    reset = 1'b1; in_reset = 1;
    #1;
    chk("rst2_cpu_dout", bus_if.cpu_dout, 8'hff);
    repeat (2) @(posedge clk);
    #2;
    s.cpu_write = 0; drive(s);
    reset = 1'b0;
    reset_model();
    in_reset = 0;
    s = '0; step(s);
    s.cpu_read = 1; s.cpu_adr = 8'h60; s.ppu_read = 1; s.ppu_adr = 8'h60; step(s);
    s = '0; step(s); step(s);

    // Random traffic.
    da = 0; pl = 0; s = '0;
    for (int i = 0; i < 3000; i++) begin
      if (da) da = ($urandom_range(0, 99) >= 15);
      else    da = ($urandom_range(0, 99) < 5);
      if (pl) pl = ($urandom_range(0, 99) >= 15);
      else    pl = ($urandom_range(0, 99) < 6);
      s.dma_active = da;
      s.ppu_lock   = pl;
      s.dma_write  = ($urandom_range(0, 99) < 40);
      s.dma_adr    = 8'($urandom_range(0, 191));
      s.dma_din    = 8'($urandom);
      s.ppu_read   = ($urandom_range(0, 99) < 40);
      s.ppu_adr    = 8'($urandom_range(0, 191));
      s.cpu_read   = ($urandom_range(0, 99) < 40);
      s.cpu_adr    = 8'($urandom_range(0, 191));
      s.cpu_din    = 8'($urandom);
      if ($urandom_range(0, 99) < 30) s.cpu_write = ~s.cpu_write;
      step(s);
    end

    s = '0;
    repeat (4) step(s);
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lr35902_oam_port.md
Name: lr35902_oam_port

Overview:
- Responder side of the OAM bus: owns the 160-byte object attribute memory and services the three agents that drive it.
  - OAM DMA engine: write-only, highest priority.
  - PPU object scan/fetch: read-only.
  - CPU at FE00–FE9F: read/write, lowest priority.
- Arbitrates between the agents, registers all read data, and blocks the CPU while DMA or the PPU own the memory, as on DMG hardware.
- Sits between the DMA engine, the PPU core and the CPU bus decoder.

Parameters:
- SIZE, 160, number of OAM bytes; addresses >= SIZE are unmapped.
- OPEN_BUS, 8'hff, value returned to the CPU for blocked or unmapped reads.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_adr  in  8  CPU offset within FE00 page
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  CPU read data, registered
- cpu_read  in  1  CPU read strobe
- cpu_write  in  1  CPU write strobe, level; commit on falling edge
- dma_active  in  1  DMA transfer in progress (blocks CPU)
- dma_adr  in  8  DMA OAM destination offset
- dma_din  in  8  DMA write data
- dma_write  in  1  DMA write strobe, level; commit every cycle high
- ppu_lock  in  1  PPU in mode 2/3, owns OAM
- ppu_adr  in  8  PPU read offset
- ppu_read  in  1  PPU read strobe
- ppu_dout  out  8  PPU read data, registered
- cpu_blocked  out  1  CPU access currently ignored

Behaviour:
- Storage: SIZE x 8 array. Not reset; contents after reset are undefined.
- Owner state machine, registered: FREE, DMA, PPU, GUARD.
  - FREE -> DMA when dma_active.
  - FREE -> PPU when ppu_lock and !dma_active.
  - DMA -> GUARD when dma_active falls, unless ppu_lock is high, then -> PPU.
  - PPU -> DMA when dma_active rises; DMA wins over PPU.
  - PPU -> GUARD when ppu_lock falls.
  - GUARD -> FREE after exactly 1 cycle, or -> DMA/PPU if requested that cycle.
- cpu_blocked = (owner != FREE) or dma_active or ppu_lock. Combinational on the inputs, so blocking takes effect the same cycle.
- DMA writes:
  - When dma_write and dma_adr < SIZE, mem[dma_adr] <= dma_din at the clock edge, in any owner state.
  - dma_write with dma_adr >= SIZE is ignored.
  - Writes with dma_active low are still honoured.
- PPU reads:
  - When ppu_read and ppu_adr < SIZE, ppu_dout <= mem[ppu_adr] one cycle later.
  - Unmapped address gives ppu_dout <= 8'h00.
  - No ppu_read: ppu_dout holds its value.
  - PPU reads are honoured in every state, including during DMA. During DMA they return the byte being written that cycle if addresses match (write-first).
- CPU writes:
  - The block tracks r_cpu_write and commits on r_cpu_write && !cpu_write, using cpu_adr and cpu_din sampled in the last high cycle (registered).
  - The commit is dropped if cpu_blocked was high in that last high cycle, or the address is >= SIZE.
  - A DMA write to the same address in the commit cycle wins; the CPU write is dropped.
- CPU reads:
  - When cpu_read, cpu_dout <= blocked or unmapped ? OPEN_BUS : mem[cpu_adr], 1-cycle latency.
  - cpu_dout holds otherwise.
- Reset (async, any time, including mid-DMA):
  - owner = FREE.
  - cpu_dout = 8'hff, ppu_dout = 8'hff.
  - r_cpu_write = 0, so no spurious commit on release.
  - cpu_blocked then follows its inputs.

Test Plan:
- Reset, then CPU writes 8'h5a to 0x10 (cpu_write high 2 cycles, then low), then CPU reads 0x10 -> cpu_dout = 8'h5a one cycle after cpu_read; cpu_blocked = 0 throughout.
- dma_active high, DMA writes 160 bytes (value = ~adr, 2 write cycles per byte), then PPU reads 0x00, 0x9f -> ppu_dout = 8'hff then 8'h60. Concurrent CPU read -> 8'hff, and CPU write to 0x20 is dropped (readback after GUARD gives the DMA value 8'hdf).
- ppu_lock high; CPU reads 0x04 -> 8'hff. ppu_lock drops; CPU read issued in the GUARD cycle -> 8'hff; next cycle -> the real byte.
- Unmapped addresses: CPU read 0xa0 -> 8'hff; PPU read 0xa5 -> 8'h00; CPU write to 0xa0 does not alias any entry (check 0x00 unchanged).
- DMA and CPU commit to 0x30 in the same cycle, DMA data 8'h11, CPU 8'h22 -> mem[0x30] = 8'h11. ppu_lock rising during DMA -> owner stays DMA, then goes to PPU on dma_active fall, with no GUARD.
- Assert reset mid-DMA with cpu_write high -> outputs are immediately 8'hff, owner FREE, and no CPU commit occurs after reset is released.
